// File: rtl/rpn_stack_ctrl_if.sv
// Token stream into the RPN stack controller: a valid/ready handshake carrying
// one operand or operator per accepted beat, with tok_last closing the expression.
interface rpn_stack_ctrl_if #(
  parameter int N = 8
);
  logic         tok_valid;
  logic         tok_ready;
  logic         tok_is_op;
  logic         tok_last;
  logic [N-1:0] tok_data;

  modport master (output tok_valid, tok_is_op, tok_last, tok_data, input tok_ready);
  modport slave  (input tok_valid, tok_is_op, tok_last, tok_data, output tok_ready);
endinterface

// File: rtl/rpn_stack_ctrl.sv
// Postfix (RPN) evaluator driving an external signed LIFO stack; one result per expression.
// Optional macro SATURATE_EN: ADD/SUB/MUL clamp to the signed range and report res_sat.
module rpn_stack_ctrl #(
  parameter int N        = 8,
  parameter int MAX_SIZE = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rpn_stack_ctrl_if.slave      tok,
  output logic                 stk_push,
  output logic                 stk_pop,
  output logic [N-1:0]         stk_din,
  input  logic [N-1:0]         stk_dout,
  input  logic                 stk_full,
  input  logic                 stk_empty,
  output logic                 res_valid,
  output logic [N-1:0]         res_data,
  output logic [1:0]           res_err,
  output logic                 res_sat
);

  localparam int DW = $clog2(MAX_SIZE + 1);
  localparam logic [DW-1:0] DEPTH_MAX = DW'(MAX_SIZE);

  localparam logic [1:0] ERR_OK    = 2'b00;
  localparam logic [1:0] ERR_UNDER = 2'b01;
  localparam logic [1:0] ERR_OVER  = 2'b10;
  localparam logic [1:0] ERR_MALF  = 2'b11;

  typedef enum logic [3:0] {
    IDLE, POP_B, POP_A, EXEC, PUSH_R, DISCARD, FINAL, RPOP, RCAP, FLUSH, DONE
  } state_t;

  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_MAX} op_t;

  state_t        state_q, state_d;
  logic [DW-1:0] depth_q, depth_d;
  logic [1:0]    err_q, err_d;
  logic          sat_q, sat_d;
  op_t           op_q, op_d;
  logic          last_q, last_d;
  logic [N-1:0]  b_q, b_d;
  logic [N-1:0]  r_q, r_d;
  logic [N-1:0]  res_q, res_d;

  logic signed [N-1:0] alu_a, alu_b, alu_r;
  logic                alu_sat;

`ifdef SATURATE_EN
  localparam logic [N-1:0] SMAX = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] SMIN = {1'b1, {(N-1){1'b0}}};
  logic [N:0]            sum_w, dif_w;
  logic signed [2*N-1:0] prod_w;
`endif

  // a is the deeper operand (popped second, arriving on stk_dout in EXEC)
  always_comb begin
    alu_a   = stk_dout;
    alu_b   = b_q;
    alu_r   = '0;
    alu_sat = 1'b0;
`ifdef SATURATE_EN
    sum_w  = {alu_a[N-1], alu_a} + {alu_b[N-1], alu_b};
    dif_w  = {alu_a[N-1], alu_a} - {alu_b[N-1], alu_b};
    prod_w = alu_a * alu_b;
    unique case (op_q)
      OP_ADD: begin
        alu_sat = (sum_w[N] != sum_w[N-1]);
        alu_r   = alu_sat ? (sum_w[N] ? SMIN : SMAX) : sum_w[N-1:0];
      end
      OP_SUB: begin
        alu_sat = (dif_w[N] != dif_w[N-1]);
        alu_r   = alu_sat ? (dif_w[N] ? SMIN : SMAX) : dif_w[N-1:0];
      end
      OP_MUL: begin
        alu_sat = (prod_w[2*N-1:N-1] != {(N+1){prod_w[N-1]}});
        alu_r   = alu_sat ? (prod_w[2*N-1] ? SMIN : SMAX) : prod_w[N-1:0];
      end
      OP_MAX:  alu_r = (alu_a > alu_b) ? alu_a : alu_b;
      default: alu_r = '0;
    endcase
`else
    unique case (op_q)
      OP_ADD:  alu_r = alu_a + alu_b;
      OP_SUB:  alu_r = alu_a - alu_b;
      OP_MUL:  alu_r = alu_a * alu_b;
      OP_MAX:  alu_r = (alu_a > alu_b) ? alu_a : alu_b;
      default: alu_r = '0;
    endcase
`endif
  end

  always_comb begin
    state_d = state_q;
    depth_d = depth_q;
    err_d   = err_q;
    sat_d   = sat_q;
    op_d    = op_q;
    last_d  = last_q;
    b_d     = b_q;
    r_d     = r_q;
    res_d   = res_q;
    tok.tok_ready = 1'b0;
    stk_push = 1'b0;
    stk_pop  = 1'b0;
    stk_din  = '0;
    unique case (state_q)
      IDLE: begin
        tok.tok_ready = 1'b1;
        if (tok.tok_valid) begin
          if (tok.tok_is_op) begin
            op_d   = op_t'(tok.tok_data[1:0]);
            last_d = tok.tok_last;
            if (depth_q < DW'(2)) begin
              err_d   = ERR_UNDER;
              state_d = tok.tok_last ? FINAL : DISCARD;
            end else begin
              state_d = POP_B;
            end
          end else if (depth_q == DEPTH_MAX) begin
            err_d   = ERR_OVER;
            state_d = tok.tok_last ? FINAL : DISCARD;
          end else begin
            stk_push = 1'b1;
            stk_din  = tok.tok_data;
            depth_d  = depth_q + DW'(1);
            state_d  = tok.tok_last ? FINAL : IDLE;
          end
        end
      end
      POP_B: begin
        stk_pop = 1'b1;
        depth_d = depth_q - DW'(1);
        state_d = POP_A;
      end
      POP_A: begin
        b_d     = stk_dout;
        stk_pop = 1'b1;
        depth_d = depth_q - DW'(1);
        state_d = EXEC;
      end
      EXEC: begin
        r_d     = alu_r;
        sat_d   = sat_q | alu_sat;
        state_d = PUSH_R;
      end
      PUSH_R: begin
        stk_push = 1'b1;
        stk_din  = r_q;
        depth_d  = depth_q + DW'(1);
        state_d  = last_q ? FINAL : IDLE;
      end
      DISCARD: begin
        tok.tok_ready = 1'b1;
        if (tok.tok_valid && tok.tok_last) state_d = FLUSH;
      end
      FINAL: begin
        if (err_q == ERR_OK && depth_q == DW'(1)) begin
          state_d = RPOP;
        end else begin
          if (err_q == ERR_OK) err_d = ERR_MALF;
          state_d = FLUSH;
        end
      end
      RPOP: begin
        stk_pop = 1'b1;
        depth_d = depth_q - DW'(1);
        state_d = RCAP;
      end
      RCAP: begin
        res_d   = stk_dout;
        state_d = DONE;
      end
      // The last pop and the move to DONE share a cycle
      FLUSH: begin
        res_d = '0;
        if (depth_q != '0) begin
          stk_pop = 1'b1;
          depth_d = depth_q - DW'(1);
        end
        if (depth_q <= DW'(1)) state_d = DONE;
      end
      DONE: begin
        err_d   = ERR_OK;
        sat_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      depth_q <= '0;
      err_q   <= ERR_OK;
      sat_q   <= 1'b0;
      op_q    <= OP_ADD;
      last_q  <= 1'b0;
      b_q     <= '0;
      r_q     <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      depth_q <= depth_d;
      err_q   <= err_d;
      sat_q   <= sat_d;
      op_q    <= op_d;
      last_q  <= last_d;
      b_q     <= b_d;
      r_q     <= r_d;
      res_q   <= res_d;
    end
  end

  assign res_valid = (state_q == DONE);
  assign res_err   = (state_q == DONE) ? err_q : ERR_OK;
  assign res_data  = (state_q == DONE) ? res_q : '0;
  assign res_sat   = (state_q == DONE) & sat_q;

  // The depth mirror must agree with the stack's own flags
  a_full:  assert property (@(posedge clk) disable iff (!rst_n) (depth_q == DEPTH_MAX) == stk_full);
  a_empty: assert property (@(posedge clk) disable iff (!rst_n) (depth_q == '0) == stk_empty);
  a_excl:  assert property (@(posedge clk) disable iff (!rst_n) !(stk_push && stk_pop));

endmodule
